line_window_gen: RTL
====================

Name: line_window_gen

Overview:
Parametrised sliding-window generator for the image pipeline. It takes a raster pixel stream and keeps ROWS-1 previous lines in circular line memories plus a COLS-deep column shift register. For every valid window position it emits one full ROWS x COLS pixel window, so convolution and filter stages can consume one window per cycle. It adds ready/valid backpressure, frame sync and row/column tagging, and supports arbitrary kernel size.

Parameters:
IMG_WIDTH, 640, pixels per line (>= COLS)
IMG_HEIGHT, 480, lines per frame (>= ROWS)
PIX_W, 8, bits per pixel
ROWS, 3, window height (2..7)
COLS, 3, window width (2..7)

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  reset; asynchronous and active-low (assert 0)
sof  in  1  start of frame; qualifies the accepted pixel as (row 0, col 0)
in_valid  in  1  input pixel valid
in_ready  out  1  block can accept a pixel this cycle
in_data  in  PIX_W  input pixel
out_valid  out  1  window valid
out_ready  in  1  downstream accepts window
out_data  out  ROWS*COLS*PIX_W  window; element (r,c) at bits [(r*COLS+c)*PIX_W +: PIX_W]
out_row  out  16  image row of the window's bottom-right pixel
out_col  out  16  image column of the window's bottom-right pixel
out_eof  out  1  window is the last of the frame

Behaviour:
- Reset (rst=0, asynchronous): counters are 0, out_valid=0, out_data=0, out_row=0, out_col=0, out_eof=0, line-memory write pointer is 0. Line-memory contents are not reset.
- Accept: a pixel is accepted when in_valid & in_ready.
- Ready: in_ready = !out_valid | out_ready. The output is a 1-deep register; there is no combinational path from in_valid to out_valid.
- Position counters (col, row):
  - col advances on each accept and wraps at IMG_WIDTH-1, at which point row increments.
  - row wraps from IMG_HEIGHT-1 to 0.
  - sof on an accepted pixel forces that pixel to (0,0); the next position is (0,1). This applies mid-frame too: the partial frame is discarded, and no windows are emitted until the new frame reaches (ROWS-1, COLS-1).
- Line memories: ROWS-1 memories of IMG_WIDTH x PIX_W, addressed by col, organised circularly.
  - On accept at col x, the column vector is formed as {mem rows oldest..newest at x, in_data}.
  - The pixel is written into the oldest slot; read-before-write at the same address returns the old data.
  - Slot rotation advances at line wrap.
- Column shift register: COLS stages, each ROWS pixels wide. It shifts on accept only, loading the new column vector.
- Window element (r,c) is pixel (row-(ROWS-1)+r, col-(COLS-1)+c): r=0 is the oldest line, c=0 is the leftmost column.
- Window emit: an accept at (row, col) with row >= ROWS-1 and col >= COLS-1 loads out_data, out_row, out_col and out_eof on the same edge and sets out_valid. Latency is 1 cycle from the accept.
  - Windows never span a line boundary: accepts at col < COLS-1 emit nothing.
  - out_eof = 1 iff row=IMG_HEIGHT-1 and col=IMG_WIDTH-1.
- Hold: while out_valid & !out_ready, all outputs stay stable and no accept occurs.
- Clear: out_valid clears on out_ready unless a new window is loaded in the same cycle.
- Window count per frame is exactly (IMG_HEIGHT-ROWS+1)*(IMG_WIDTH-COLS+1).
- Counters are 16 bits, wide enough for any supported IMG_WIDTH and IMG_HEIGHT.

Test Plan:
- Common setup: IMG_WIDTH=8, IMG_HEIGHT=6, ROWS=COLS=3; pixel value = row*16+col.
- Reset: drive rst=0 -> out_valid=0, in_ready=1, out_data=0. Release rst, idle 10 cycles -> no output.
- Full frame, out_ready=1: send 48 pixels, sof on the first -> exactly 24 windows.
  - First window appears 1 cycle after pixel (2,2): elements (0,0)=0x00, (1,1)=0x11, (2,2)=0x22, out_row=2, out_col=2.
  - Last window: (2,2)=0x57, (0,0)=0x35, out_eof=1.
- Backpressure: hold out_ready=0 for 5 cycles mid-frame with in_valid=1 -> in_ready=0 and out_data stable. Total windows still 24, none duplicated, ordering correct.
- Line boundary: accepts at col 0 and col 1 of rows 2..5 produce no out_valid. The window at (3,2) has (0,0)=0x10, not data from the previous line.
- sof mid-frame: assert sof at pixel (3,4) -> the in-progress window stream stops. The next window is tagged (2,2), with contents from the new frame only.
- Config ROWS=COLS=5 and async reset: ROWS=COLS=5 with the same frame -> 8 windows, first (0,0)=0x00 and (4,4)=0x44. Asserting rst between clock edges mid-frame drops out_valid immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/line_window_gen.sv
// Sliding ROWS x COLS window generator over a raster pixel stream.
// Previous lines live in circular line memories; columns shift through a register chain.
module line_window_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIX_W      = 8,
    parameter int ROWS       = 3,
    parameter int COLS       = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sof,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [PIX_W-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ROWS*COLS*PIX_W-1:0]    out_data,
    output logic [15:0]                   out_row,
    output logic [15:0]                   out_col,
    output logic                          out_eof
);

    localparam int NLM = ROWS - 1;
    localparam int AW  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int SW  = (NLM > 1) ? $clog2(NLM) : 1;
    localparam int VW  = ROWS * PIX_W;

    logic [15:0]                col_cnt;
    logic [15:0]                row_cnt;
    logic [15:0]                cur_col;
    logic [15:0]                cur_row;
    logic [15:0]                nxt_col;
    logic [15:0]                nxt_row;
    logic [SW-1:0]              wr_slot;
    logic                       accept;
    logic                       line_end;
    logic                       emit;
    logic [PIX_W-1:0]           line_mem [NLM][IMG_WIDTH];
    logic [VW-1:0]              col_vec;
    logic [VW-1:0]              col_shift [COLS];
    logic [ROWS*COLS*PIX_W-1:0] win_nxt;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // sof re-tags the accepted pixel as (0,0) regardless of the running counters
    assign cur_col  = sof ? '0 : col_cnt;
    assign cur_row  = sof ? '0 : row_cnt;
    assign line_end = (cur_col == 16'(IMG_WIDTH - 1));
    assign emit     = accept && (cur_row >= 16'(ROWS - 1)) && (cur_col >= 16'(COLS - 1));

    always_comb begin
        nxt_col = cur_col + 16'd1;
        nxt_row = cur_row;
        if (line_end) begin
            nxt_col = '0;
            nxt_row = (cur_row == 16'(IMG_HEIGHT - 1)) ? '0 : cur_row + 16'd1;
        end
    end

    // ---- column vector: wr_slot holds the oldest line, slots after it are newer
    always_comb begin
        col_vec = '0;
        for (int r = 0; r < NLM; r++) begin
            col_vec[r*PIX_W +: PIX_W] = line_mem[(int'(wr_slot) + r) % NLM][cur_col[AW-1:0]];
        end
        col_vec[NLM*PIX_W +: PIX_W] = in_data;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            line_mem[int'(wr_slot)][cur_col[AW-1:0]] <= in_data;
        end
    end

    // ---- column shift register: newest column at index COLS-1
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int c = 0; c < COLS - 1; c++) begin
                col_shift[c] <= col_shift[c+1];
            end
            col_shift[COLS-1] <= col_vec;
        end
    end

    always_comb begin
        win_nxt = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS - 1; c++) begin
                win_nxt[(r*COLS+c)*PIX_W +: PIX_W] = col_shift[c+1][r*PIX_W +: PIX_W];
            end
            win_nxt[(r*COLS+COLS-1)*PIX_W +: PIX_W] = col_vec[r*PIX_W +: PIX_W];
        end
    end

    // ---- position counters, slot rotation and 1-deep output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_cnt   <= '0;
            row_cnt   <= '0;
            wr_slot   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_eof   <= 1'b0;
        end else begin
            if (accept) begin
                col_cnt <= nxt_col;
                row_cnt <= nxt_row;
                if (line_end) begin
                    wr_slot <= (wr_slot == SW'(NLM - 1)) ? '0 : wr_slot + SW'(1);
                end
            end
            if (emit) begin
                out_valid <= 1'b1;
                out_data  <= win_nxt;
                out_row   <= cur_row;
                out_col   <= cur_col;
                out_eof   <= (cur_row == 16'(IMG_HEIGHT - 1)) && line_end;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
